rover_drive_sequencer: RTL and testbench
========================================

# rover_drive_sequencer

Generates the drive command set (`direction`, `speedLeft`, `speedRight`) and the overcurrent fault flag consumed by the rover's 7-segment status display and the motor drivers. It converts an operator/autonomy request (direction code plus target speed level) into slew-limited speed changes. Before any direction reversal or turn, speed ramps down to 0. A filtered left-motor overcurrent input latches a fault that forces an immediate stop.

## Interface
- `RAMP_DIV`, default 1_000_000: clock cycles per ramp tick (≥2).
- `OC_FILTER`, default 16: consecutive cycles `overcurrent` must be high before a fault latches (≥1).
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `dir_req`  in  3  requested direction: 000 stop, 001 forward, 010 backward, 011 left, 100 right; 101–111 treated as stop.
- `speed_req`  in  3  target speed level 0–7; ignored (target 0) when the request is stop.
- `overcurrent`  in  1  raw left-motor overcurrent comparator, already synchronized.
- `fault_clear`  in  1  level; releases a latched fault when `overcurrent` is low.
- `direction`  out  4  registered: 0000 stop, 1001 forward, 0110 backward, 0101 left, 1010 right.
- `speedLeft`  out  3  registered current speed level, left motor.
- `speedRight`  out  3  registered current speed level, right motor; always equals `speedLeft`.
- `fault`  out  1  registered latched overcurrent fault; drives the display's fault/reset input.

## Operation
- Tick counter: counts 0..RAMP_DIV-1 and wraps. `tick` = (count == RAMP_DIV-1). The counter is free-running and is cleared only by `reset`.
- `req_code` is the 4-bit direction encoding of `dir_req`. `target` = 0 if `req_code` is 0000, else `speed_req`.
- States:
  - IDLE: speed 0, direction 0000.
  - RUN: direction == `req_code` and speed slewing toward `target`.
  - BRAKE: direction != `req_code`, speed ramping down.
  - FAULT.
- IDLE:
  - On tick with `req_code` != 0000: direction <= `req_code`, speed stays 0, go to RUN. Speed starts ramping on the next tick.
  - A stop request keeps IDLE.
- RUN, on tick:
  - `req_code` differs from direction: go to BRAKE; speed -1 on the same tick if >0.
  - Otherwise: speed moves one level toward `target` (±1), holds if equal.
  - Speed reaches 0 with `req_code` 0000: direction <= 0000, go to IDLE on that same tick.
- BRAKE, on tick:
  - speed >0: speed -1.
  - speed ==0: direction <= `req_code`. Go to IDLE if `req_code` is 0000, else RUN.
  - The request may change during BRAKE. The value sampled at the speed==0 tick wins.
  - If the request returns to the current direction during BRAKE, go back to RUN on the next tick and resume slewing toward `target`.
- Overcurrent filter:
  - A counter increments while `overcurrent` is high and clears to 0 on any low cycle.
  - When the count reaches OC_FILTER, enter FAULT on the next edge.
- FAULT:
  - Entry is immediate from any state and ignores `tick`.
  - speed <= 0, direction <= 0000, `fault` <= 1.
  - Exit to IDLE (`fault` <= 0) on the first edge where `fault_clear` = 1 and `overcurrent` = 0.
- Priority: `reset` > fault entry > fault hold > tick-driven FSM.
- Speed arithmetic saturates at 0 and 7; there is no wrap.

## Timing
- Reset values: `direction` 0000, `speedLeft`/`speedRight` 0, `fault` 0, state IDLE, tick and filter counters 0.
- All outputs are registered. Request inputs are sampled only on tick edges (except the filter and `fault_clear`).
- Request-to-output latency: up to RAMP_DIV cycles to the first change, then one level per RAMP_DIV cycles.
- Fault latency: `overcurrent` high for OC_FILTER consecutive cycles ⇒ `fault` = 1 and outputs zeroed on edge OC_FILTER+1 after the first high sample.
- Clear latency: 1 cycle. The next tick may leave IDLE.
- Reset asserted mid-ramp or in FAULT: all outputs reach reset values at the next edge, with no ramp-down.

## Test plan
- Ramp up (RAMP_DIV=4): reset, then `dir_req`=001, `speed_req`=5 → direction 1001 at tick 1; speed 1,2,3,4,5 on ticks 2–6; speed holds 5 thereafter, both speed outputs equal.
- Reversal: while running forward at 5, set `dir_req`=010 → speed 4,3,2,1,0 on successive ticks while direction stays 1001; next tick direction 0110; then speed ramps to 5.
- Stop and invalid code: while running at 3, set `dir_req`=111 → speed ramps 2,1,0, and direction 0000 on the tick where speed hits 0. Then request 011 with `speed_req`=2 → direction 0101, and speed reaches 2 two ticks after the direction change.
- Fault filter (OC_FILTER=16): an `overcurrent` pulse of 15 cycles → no fault. A pulse of 16 cycles → `fault`=1, direction 0000, speeds 0 at the next edge, mid-ramp, without waiting for a tick.
- Fault clear: `fault_clear`=1 while `overcurrent`=1 → `fault` stays 1. Drop `overcurrent` → `fault`=0 at the next edge and state IDLE. A standing forward request restarts from speed 0.
- Reset mid-operation: assert `reset` for one cycle while running at 6 → next edge all outputs 0. After release, the first tick occurs RAMP_DIV cycles later.

Source files
------------

// File: rtl/rover_drive_sequencer.sv
// rover_drive_sequencer
//
// Turns a direction/speed request into slew-limited motor commands. Speed
// changes by at most one level per ramp tick. Any change of direction first
// ramps the speed down to 0. A filtered overcurrent input latches a fault
// that zeroes the outputs at once, without waiting for a tick.
//
// Parameters:
//   RAMP_DIV   clock cycles per ramp tick (>= 2)
//   OC_FILTER  consecutive high cycles of overcurrent before a fault latches (>= 1)
//
// Ports:
//   clock        system clock; every register updates on its rising edge
//   reset        synchronous, active-high
//   dir_req      requested direction: 0 stop, 1 fwd, 2 back, 3 left, 4 right,
//                5-7 are treated as stop
//   speed_req    target speed level 0-7; ignored when the request is stop
//   overcurrent  left-motor overcurrent comparator, already synchronized
//   fault_clear  level; releases a latched fault once overcurrent is low
//   direction    registered 4-bit direction code for the motor drivers
//   speedLeft    registered current speed level, left motor
//   speedRight   registered current speed level, right motor (= speedLeft)
//   fault        registered latched overcurrent fault
module rover_drive_sequencer #(
  parameter int RAMP_DIV  = 1_000_000,
  parameter int OC_FILTER = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] dir_req,
  input  logic [2:0] speed_req,
  input  logic       overcurrent,
  input  logic       fault_clear,
  output logic [3:0] direction,
  output logic [2:0] speedLeft,
  output logic [2:0] speedRight,
  output logic       fault
);

  localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int OW = $clog2(OC_FILTER + 1);

  localparam logic [3:0] DIR_STOP  = 4'b0000;
  localparam logic [3:0] DIR_FWD   = 4'b1001;
  localparam logic [3:0] DIR_BACK  = 4'b0110;
  localparam logic [3:0] DIR_LEFT  = 4'b0101;
  localparam logic [3:0] DIR_RIGHT = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_BRAKE,
    S_FAULT
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   tick_count_reg, tick_count_next;
  logic [OW-1:0]   oc_count_reg, oc_count_next;
  logic [3:0]      dir_reg, dir_next;
  logic [2:0]      speed_reg, speed_next;
  logic            fault_reg, fault_next;

  logic            tick;
  logic            oc_trip;
  logic [3:0]      req_code;
  logic [2:0]      target;
  logic [2:0]      speed_up;
  logic [2:0]      speed_down;
  logic [2:0]      speed_toward;

  // Free-running ramp tick divider; only reset clears it.
  assign tick            = (tick_count_reg == TW'(RAMP_DIV - 1));
  assign tick_count_next = tick ? '0 : tick_count_reg + TW'(1);

  // Overcurrent run-length counter. Saturates so a long overcurrent never
  // wraps back below the trip level.
  always_comb begin
    oc_count_next = '0;
    if (overcurrent) begin
      if (oc_count_reg == OW'(OC_FILTER)) begin
        oc_count_next = oc_count_reg;
      end else begin
        oc_count_next = oc_count_reg + OW'(1);
      end
    end
  end

  assign oc_trip = (oc_count_reg == OW'(OC_FILTER));

  always_comb begin
    req_code = DIR_STOP;
    case (dir_req)
      3'b001:  req_code = DIR_FWD;
      3'b010:  req_code = DIR_BACK;
      3'b011:  req_code = DIR_LEFT;
      3'b100:  req_code = DIR_RIGHT;
      default: req_code = DIR_STOP;
    endcase
  end

  assign target = (req_code == DIR_STOP) ? 3'd0 : speed_req;

  // Saturating one-level steps.
  assign speed_up   = (speed_reg == 3'd7) ? 3'd7 : speed_reg + 3'd1;
  assign speed_down = (speed_reg == 3'd0) ? 3'd0 : speed_reg - 3'd1;

  always_comb begin
    speed_toward = speed_reg;
    if (speed_reg < target) begin
      speed_toward = speed_up;
    end else if (speed_reg > target) begin
      speed_toward = speed_down;
    end
  end

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    speed_next = speed_reg;
    fault_next = fault_reg;

    if (state_reg != S_FAULT && oc_trip) begin
      // Fault entry overrides the ramp and ignores the tick.
      state_next = S_FAULT;
      dir_next   = DIR_STOP;
      speed_next = 3'd0;
      fault_next = 1'b1;
    end else if (state_reg == S_FAULT) begin
      dir_next   = DIR_STOP;
      speed_next = 3'd0;
      fault_next = 1'b1;
      if (fault_clear && !overcurrent) begin
        state_next = S_IDLE;
        fault_next = 1'b0;
      end
    end else if (tick) begin
      case (state_reg)
        S_IDLE: begin
          speed_next = 3'd0;
          dir_next   = DIR_STOP;
          if (req_code != DIR_STOP) begin
            // Direction is committed first; speed starts on the next tick.
            dir_next   = req_code;
            state_next = S_RUN;
          end
        end

        S_RUN: begin
          if (req_code != dir_reg) begin
            speed_next = speed_down;
            state_next = S_BRAKE;
            // A stop that lands on 0 drops straight to idle on this tick.
            if (speed_down == 3'd0 && req_code == DIR_STOP) begin
              dir_next   = DIR_STOP;
              state_next = S_IDLE;
            end
          end else begin
            speed_next = speed_toward;
          end
        end

        S_BRAKE: begin
          if (req_code == dir_reg) begin
            // Request went back to the current direction: resume slewing.
            state_next = S_RUN;
          end else if (speed_reg != 3'd0) begin
            speed_next = speed_down;
            if (speed_down == 3'd0 && req_code == DIR_STOP) begin
              dir_next   = DIR_STOP;
              state_next = S_IDLE;
            end
          end else begin
            // Stationary: the request sampled now picks the new direction.
            dir_next   = req_code;
            state_next = (req_code == DIR_STOP) ? S_IDLE : S_RUN;
          end
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      tick_count_reg <= '0;
      oc_count_reg   <= '0;
      dir_reg        <= DIR_STOP;
      speed_reg      <= 3'd0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tick_count_reg <= tick_count_next;
      oc_count_reg   <= oc_count_next;
      dir_reg        <= dir_next;
      speed_reg      <= speed_next;
      fault_reg      <= fault_next;
    end
  end

  assign direction  = dir_reg;
  assign speedLeft  = speed_reg;
  assign speedRight = speed_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_rover_drive_sequencer.sv
// Directed testbench for rover_drive_sequencer with RAMP_DIV=4, OC_FILTER=16.
// The bench keeps its own count of edges since reset (phase) to know where
// ramp ticks fall, so expected values never come from the DUT.
module tb_rover_drive_sequencer;

  logic       clock;
  logic       reset;
  logic [2:0] dir_req;
  logic [2:0] speed_req;
  logic       overcurrent;
  logic       fault_clear;
  logic [3:0] direction;
  logic [2:0] speedLeft;
  logic [2:0] speedRight;
  logic       fault;

  int n_cmp;
  int n_err;
  int phase;

  rover_drive_sequencer #(
    .RAMP_DIV (4),
    .OC_FILTER(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dir_req    (dir_req),
    .speed_req  (speed_req),
    .overcurrent(overcurrent),
    .fault_clear(fault_clear),
    .direction  (direction),
    .speedLeft  (speedLeft),
    .speedRight (speedRight),
    .fault      (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
    if (reset) phase = 0;
    else phase = (phase + 1) % 4;
  endtask

  // Advance to the next ramp-tick edge.
  task automatic next_tick();
    do step(); while (phase != 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; dir_req = 3'b001; speed_req = 3'd7;
    overcurrent = 1'b0; fault_clear = 1'b0;
    step(); step();
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL reset_dir: got %b expected 0000", direction); end
    n_cmp++; if (speedLeft !== 3'd0) begin n_err++; $display("FAIL reset_speedL: got %0d expected 0", speedLeft); end
    n_cmp++; if (speedRight !== 3'd0) begin n_err++; $display("FAIL reset_speedR: got %0d expected 0", speedRight); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b expected 0", fault); end
    $display("reset: dir=%b L=%0d R=%0d fault=%b", direction, speedLeft, speedRight, fault);
    reset = 1'b0;
  endtask

  task automatic test_ramp_up();
    dir_req = 3'b001; speed_req = 3'd5;
    repeat (3) step();
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL ramp_pretick_dir: got %b expected 0000", direction); end
    step();
    n_cmp++; if (direction !== 4'b1001) begin n_err++; $display("FAIL ramp_tick1_dir: got %b expected 1001", direction); end
    n_cmp++; if (speedLeft !== 3'd0) begin n_err++; $display("FAIL ramp_tick1_speed: got %0d expected 0", speedLeft); end
    for (int k = 1; k <= 5; k++) begin
      next_tick();
      $display("ramp_up tick: dir=%b L=%0d R=%0d expected %0d", direction, speedLeft, speedRight, k);
      n_cmp++; if (speedLeft !== 3'(k)) begin n_err++; $display("FAIL ramp_speedL: got %0d expected %0d", speedLeft, k); end
      n_cmp++; if (speedRight !== 3'(k)) begin n_err++; $display("FAIL ramp_speedR: got %0d expected %0d", speedRight, k); end
      n_cmp++; if (direction !== 4'b1001) begin n_err++; $display("FAIL ramp_dir: got %b expected 1001", direction); end
    end
    repeat (2) begin
      next_tick();
      n_cmp++; if (speedLeft !== 3'd5) begin n_err++; $display("FAIL ramp_hold: got %0d expected 5", speedLeft); end
    end
  endtask

  task automatic test_reversal();
    dir_req = 3'b010;
    for (int k = 4; k >= 0; k--) begin
      next_tick();
      $display("reversal brake tick: dir=%b L=%0d expected %0d", direction, speedLeft, k);
      n_cmp++; if (speedLeft !== 3'(k)) begin n_err++; $display("FAIL rev_brake_speed: got %0d expected %0d", speedLeft, k); end
      n_cmp++; if (direction !== 4'b1001) begin n_err++; $display("FAIL rev_brake_dir: got %b expected 1001", direction); end
    end
    next_tick();
    n_cmp++; if (direction !== 4'b0110) begin n_err++; $display("FAIL rev_newdir: got %b expected 0110", direction); end
    n_cmp++; if (speedLeft !== 3'd0) begin n_err++; $display("FAIL rev_newdir_speed: got %0d expected 0", speedLeft); end
    for (int k = 1; k <= 5; k++) begin
      next_tick();
      $display("reversal ramp tick: dir=%b L=%0d expected %0d", direction, speedLeft, k);
      n_cmp++; if (speedLeft !== 3'(k)) begin n_err++; $display("FAIL rev_ramp_speed: got %0d expected %0d", speedLeft, k); end
    end
  endtask

  task automatic test_stop_invalid();
    speed_req = 3'd3;
    next_tick(); next_tick();
    n_cmp++; if (speedLeft !== 3'd3) begin n_err++; $display("FAIL stop_down_to3: got %0d expected 3", speedLeft); end
    dir_req = 3'b111;
    for (int k = 2; k >= 1; k--) begin
      next_tick();
      $display("stop tick: dir=%b L=%0d expected %0d", direction, speedLeft, k);
      n_cmp++; if (speedLeft !== 3'(k)) begin n_err++; $display("FAIL stop_speed: got %0d expected %0d", speedLeft, k); end
      n_cmp++; if (direction !== 4'b0110) begin n_err++; $display("FAIL stop_dir_hold: got %b expected 0110", direction); end
    end
    next_tick();
    n_cmp++; if (speedLeft !== 3'd0) begin n_err++; $display("FAIL stop_zero_speed: got %0d expected 0", speedLeft); end
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL stop_zero_dir: got %b expected 0000", direction); end
    next_tick();
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL stop_idle_dir: got %b expected 0000", direction); end
    dir_req = 3'b011; speed_req = 3'd2;
    next_tick();
    n_cmp++; if (direction !== 4'b0101) begin n_err++; $display("FAIL left_dir: got %b expected 0101", direction); end
    n_cmp++; if (speedLeft !== 3'd0) begin n_err++; $display("FAIL left_start_speed: got %0d expected 0", speedLeft); end
    next_tick();
    n_cmp++; if (speedLeft !== 3'd1) begin n_err++; $display("FAIL left_speed1: got %0d expected 1", speedLeft); end
    next_tick();
    n_cmp++; if (speedLeft !== 3'd2) begin n_err++; $display("FAIL left_speed2: got %0d expected 2", speedLeft); end
    $display("left: dir=%b L=%0d R=%0d", direction, speedLeft, speedRight);
  endtask

  task automatic test_fault_filter();
    // 15-cycle pulse must not trip.
    overcurrent = 1'b1;
    repeat (15) step();
    overcurrent = 1'b0;
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL oc15_fault: got %b expected 0", fault); end
    repeat (5) step();
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL oc15_fault_late: got %b expected 0", fault); end
    n_cmp++; if (speedLeft !== 3'd2) begin n_err++; $display("FAIL oc15_speed: got %0d expected 2", speedLeft); end
    n_cmp++; if (direction !== 4'b0101) begin n_err++; $display("FAIL oc15_dir: got %b expected 0101", direction); end
    // 16-cycle pulse during a ramp trips one edge after the 16th high sample.
    speed_req = 3'd7; overcurrent = 1'b1;
    repeat (16) step();
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL oc16_early_fault: got %b expected 0", fault); end
    n_cmp++; if (speedLeft !== 3'd6) begin n_err++; $display("FAIL oc16_midramp_speed: got %0d expected 6", speedLeft); end
    overcurrent = 1'b0;
    step();
    $display("fault entry: dir=%b L=%0d R=%0d fault=%b", direction, speedLeft, speedRight, fault);
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL oc16_fault: got %b expected 1", fault); end
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL oc16_dir: got %b expected 0000", direction); end
    n_cmp++; if (speedLeft !== 3'd0) begin n_err++; $display("FAIL oc16_speedL: got %0d expected 0", speedLeft); end
    n_cmp++; if (speedRight !== 3'd0) begin n_err++; $display("FAIL oc16_speedR: got %0d expected 0", speedRight); end
  endtask

  task automatic test_fault_clear();
    dir_req = 3'b001; speed_req = 3'd3;
    fault_clear = 1'b0; overcurrent = 1'b0;
    step();
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL clear_hold_noclear: got %b expected 1", fault); end
    fault_clear = 1'b1; overcurrent = 1'b1;
    step();
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL clear_blocked1: got %b expected 1", fault); end
    step();
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL clear_blocked2: got %b expected 1", fault); end
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL clear_blocked_dir: got %b expected 0000", direction); end
    overcurrent = 1'b0;
    step();
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL clear_release: got %b expected 0", fault); end
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL clear_idle_dir: got %b expected 0000", direction); end
    fault_clear = 1'b0;
    next_tick();
    n_cmp++; if (direction !== 4'b1001) begin n_err++; $display("FAIL clear_restart_dir: got %b expected 1001", direction); end
    n_cmp++; if (speedLeft !== 3'd0) begin n_err++; $display("FAIL clear_restart_speed0: got %0d expected 0", speedLeft); end
    next_tick();
    n_cmp++; if (speedLeft !== 3'd1) begin n_err++; $display("FAIL clear_restart_speed1: got %0d expected 1", speedLeft); end
    $display("after clear: dir=%b L=%0d fault=%b", direction, speedLeft, fault);
  endtask

  task automatic test_reset_mid();
    speed_req = 3'd6;
    for (int k = 2; k <= 6; k++) next_tick();
    n_cmp++; if (speedLeft !== 3'd6) begin n_err++; $display("FAIL midreset_pre_speed: got %0d expected 6", speedLeft); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (speedLeft !== 3'd0) begin n_err++; $display("FAIL midreset_speed: got %0d expected 0", speedLeft); end
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL midreset_dir: got %b expected 0000", direction); end
    repeat (3) step();
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL midreset_early_tick: got %b expected 0000", direction); end
    step();
    n_cmp++; if (direction !== 4'b1001) begin n_err++; $display("FAIL midreset_first_tick: got %b expected 1001", direction); end
    $display("after mid reset: dir=%b L=%0d", direction, speedLeft);
  endtask

  task automatic test_reset_in_fault();
    overcurrent = 1'b1;
    repeat (16) step();
    overcurrent = 1'b0;
    step();
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL rf_fault_set: got %b expected 1", fault); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rf_fault_cleared: got %b expected 0", fault); end
    n_cmp++; if (direction !== 4'b0000) begin n_err++; $display("FAIL rf_dir: got %b expected 0000", direction); end
    $display("reset in fault: dir=%b fault=%b", direction, fault);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    phase = 0;
    test_reset();
    test_ramp_up();
    test_reversal();
    test_stop_invalid();
    test_fault_filter();
    test_fault_clear();
    test_reset_mid();
    test_reset_in_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at time %0t, expected to finish", $time);
    $fatal(1, "timeout");
  end

endmodule
